// File: rtl/memory_stage.sv
// memory_stage: Y-86 E->M pipeline register, byte-addressed data memory, m_* results
module memory_stage #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        M_stall,
    input  logic        M_bubble,
    input  logic [3:0]  e_stat,
    input  logic [3:0]  e_icode,
    input  logic        e_Cnd,
    input  logic [63:0] e_valE,
    input  logic [63:0] e_valA,
    input  logic [3:0]  e_dstE,
    input  logic [3:0]  e_dstM,
    input  logic        dbg_we,
    input  logic [63:0] dbg_addr,
    input  logic [7:0]  dbg_wdata,
    output logic [3:0]  M_icode,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic [63:0] m_valM,
    output logic [3:0]  m_stat,
    output logic        halted
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam logic [3:0] AOK = 4'b1000;
    localparam logic [3:0] ADR = 4'b0010;
    localparam logic [3:0] I_NOP = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET = 4'h9;
    localparam logic [3:0] I_PUSHQ = 4'hA;
    localparam logic [3:0] I_POPQ = 4'hB;
    localparam logic [3:0] R_NONE = 4'hF;
    localparam logic [63:0] LAST_QUAD = 64'(MEM_BYTES - 8);
    localparam logic [63:0] MEM_SIZE = 64'(MEM_BYTES);

    logic [7:0]    mem [MEM_BYTES];
    logic [3:0]    M_stat;
    logic [63:0]   mem_addr;
    logic [AW-1:0] base;
    logic          mem_read;
    logic          mem_write;
    logic          addr_ok;
    logic          do_write;

    // E->M register: reset and bubble both load a nop, stall holds
    always_ff @(posedge clk) begin
        if (rst || M_bubble) begin
            M_stat  <= AOK;
            M_icode <= I_NOP;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= R_NONE;
            M_dstM  <= R_NONE;
        end else if (!M_stall) begin
            M_stat  <= e_stat;
            M_icode <= e_icode;
            M_Cnd   <= e_Cnd;
            M_valE  <= e_valE;
            M_valA  <= e_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= e_dstM;
        end
    end

    // address select, bounds check, status and little-endian quad read
    always_comb begin
        mem_addr  = (M_icode == I_RET || M_icode == I_POPQ) ? M_valA : M_valE;
        base      = mem_addr[AW-1:0];
        mem_read  = M_icode == I_MRMOVQ || M_icode == I_RET || M_icode == I_POPQ;
        mem_write = M_icode == I_RMMOVQ || M_icode == I_PUSHQ || M_icode == I_CALL;
        addr_ok   = mem_addr <= LAST_QUAD;
        m_stat    = ((mem_read || mem_write) && !addr_ok) ? ADR : M_stat;
        do_write  = mem_write && addr_ok && M_stat == AOK && !halted && !rst;
        m_valM    = '0;
        for (int i = 0; i < 8; i++)
            m_valM[8*i +: 8] = (mem_read && addr_ok) ? mem[base + AW'(i)] : 8'h00;
    end

    // sticky halt once a non-AOK status reaches M
    always_ff @(posedge clk) begin
        if (rst)
            halted <= 1'b0;
        else if (m_stat != AOK)
            halted <= 1'b1;
    end

    // memory writes: backdoor byte first so a same-byte pipeline store overrides it
    always_ff @(posedge clk) begin
        if (!rst && dbg_we && dbg_addr < MEM_SIZE)
            mem[dbg_addr[AW-1:0]] <= dbg_wdata;
        if (do_write)
            for (int i = 0; i < 8; i++)
                mem[base + AW'(i)] <= M_valA[8*i +: 8];
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed vectors with a cycle-tagged scoreboard and negedge monitor
module tb_memory_stage;
    localparam int MEM_BYTES = 1024;
    localparam logic [3:0] AOK = 4'b1000;
    localparam logic [3:0] ADR = 4'b0010;
    localparam int S_VALM = 0, S_STAT = 1, S_HALT = 2, S_ICODE = 3, S_VALE = 4, S_DSTE = 5, S_DSTM = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        M_stall = 1'b0;
    logic        M_bubble = 1'b0;
    logic [3:0]  e_stat = AOK;
    logic [3:0]  e_icode = 4'h1;
    logic        e_Cnd = 1'b0;
    logic [63:0] e_valE = '0;
    logic [63:0] e_valA = '0;
    logic [3:0]  e_dstE = 4'hF;
    logic [3:0]  e_dstM = 4'hF;
    logic        dbg_we = 1'b0;
    logic [63:0] dbg_addr = '0;
    logic [7:0]  dbg_wdata = '0;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [63:0] m_valM;
    logic [3:0]  m_stat;
    logic        halted;

    memory_stage #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst(rst), .M_stall(M_stall), .M_bubble(M_bubble),
        .e_stat(e_stat), .e_icode(e_icode), .e_Cnd(e_Cnd), .e_valE(e_valE), .e_valA(e_valA),
        .e_dstE(e_dstE), .e_dstM(e_dstM), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE),
        .M_dstM(M_dstM), .m_valM(m_valM), .m_stat(m_stat), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          sel;
        logic [63:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [63:0] got;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] obs(input int sel);
        case (sel)
            S_VALM:  return m_valM;
            S_STAT:  return 64'(m_stat);
            S_HALT:  return 64'(halted);
            S_ICODE: return 64'(M_icode);
            S_VALE:  return M_valE;
            S_DSTE:  return 64'(M_dstE);
            default: return 64'(M_dstM);
        endcase
    endfunction

    // monitor: every expectation tagged with this cycle is checked mid-cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            got = obs(cur.sel);
            tests++;
            if (cur.cyc != cyc || got !== cur.val) begin
                fails++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, checked %0d)",
                         cur.name, got, cur.val, cur.cyc, cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string name, input int sel, input logic [63:0] val);
        sb.push_back('{cyc: cyc, sel: sel, val: val, name: name});
    endtask

    task automatic issue(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                         input logic [3:0] de = 4'hF, input logic [3:0] dm = 4'hF);
        e_stat = AOK; e_icode = ic; e_Cnd = 1'b1; e_valE = ve; e_valA = va; e_dstE = de; e_dstM = dm;
        step();
        e_icode = 4'h1; e_Cnd = 1'b0; e_valE = '0; e_valA = '0; e_dstE = 4'hF; e_dstM = 4'hF;
    endtask

    task automatic poke(input logic [63:0] a, input logic [7:0] d);
        dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
        step();
        dbg_we = 1'b0;
    endtask

    initial begin
        step();
        step();
        expect_v("reset_icode", S_ICODE, 64'h1);
        expect_v("reset_dstE", S_DSTE, 64'hF);
        expect_v("reset_dstM", S_DSTM, 64'hF);
        expect_v("reset_stat", S_STAT, 64'(AOK));
        expect_v("reset_halted", S_HALT, 64'h0);
        expect_v("reset_valM", S_VALM, 64'h0);
        rst = 1'b0;
        // dbg preload and quad load
        for (int i = 0; i < 8; i++) poke(64'h100 + 64'(i), 8'(i + 1));
        issue(4'h5, 64'h100, 64'h0, 4'hF, 4'h0);
        expect_v("mrmovq_0x100", S_VALM, 64'h0807060504030201);
        expect_v("mrmovq_0x100_stat", S_STAT, 64'(AOK));
        // store then load
        issue(4'h4, 64'h20, 64'hDEADBEEF00C0FFEE);
        expect_v("rmmovq_stat", S_STAT, 64'(AOK));
        expect_v("rmmovq_no_read", S_VALM, 64'h0);
        issue(4'h5, 64'h20, 64'h0, 4'hF, 4'h1);
        expect_v("load_after_store", S_VALM, 64'hDEADBEEF00C0FFEE);
        // stall holds, bubble overrides stall
        issue(4'h3, 64'h1234, 64'h0, 4'h2);
        expect_v("irmovq_icode", S_ICODE, 64'h3);
        M_stall = 1'b1;
        issue(4'h6, 64'h999, 64'h0, 4'h5);
        expect_v("stall_icode", S_ICODE, 64'h3);
        expect_v("stall_valE", S_VALE, 64'h1234);
        expect_v("stall_dstE", S_DSTE, 64'h2);
        M_bubble = 1'b1;
        issue(4'h6, 64'h999, 64'h0, 4'h5, 4'h6);
        expect_v("bubble_icode", S_ICODE, 64'h1);
        expect_v("bubble_dstE", S_DSTE, 64'hF);
        expect_v("bubble_dstM", S_DSTM, 64'hF);
        M_stall = 1'b0;
        M_bubble = 1'b0;
        // popq reads via valA, call writes via valE
        poke(64'h80, 8'h55);
        for (int i = 1; i < 8; i++) poke(64'h80 + 64'(i), 8'h00);
        issue(4'hB, 64'h88, 64'h80, 4'h4, 4'h3);
        expect_v("popq_valM", S_VALM, 64'h55);
        issue(4'h8, 64'h78, 64'h13);
        expect_v("call_stat", S_STAT, 64'(AOK));
        issue(4'h9, 64'h80, 64'h78);
        expect_v("ret_reads_call", S_VALM, 64'h13);
        // pipeline store beats a backdoor write to the same byte
        issue(4'h4, 64'h30, 64'h1122334455667788);
        dbg_we = 1'b1; dbg_addr = 64'h30; dbg_wdata = 8'hAA;
        issue(4'h5, 64'h30, 64'h0);
        dbg_we = 1'b0;
        expect_v("pipe_beats_dbg", S_VALM, 64'h1122334455667788);
        // highest legal quad address
        issue(4'h4, 64'(MEM_BYTES - 8), 64'hA5A5000011112222);
        expect_v("store_last_quad_stat", S_STAT, 64'(AOK));
        issue(4'h5, 64'(MEM_BYTES - 8), 64'h0);
        expect_v("load_last_quad", S_VALM, 64'hA5A5000011112222);
        // reset with a store sitting in M
        issue(4'h4, 64'h50, 64'h0);
        issue(4'h4, 64'h50, 64'h77);
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_v("rst_store_icode", S_ICODE, 64'h1);
        expect_v("rst_store_halted", S_HALT, 64'h0);
        expect_v("rst_store_stat", S_STAT, 64'(AOK));
        issue(4'h5, 64'h50, 64'h0);
        expect_v("rst_store_no_write", S_VALM, 64'h0);
        // out-of-range store halts and blocks later stores
        issue(4'h4, 64'h40, 64'h0102030405060708);
        issue(4'h4, 64'(MEM_BYTES - 7), 64'hFFFFFFFFFFFFFFFF);
        expect_v("bad_store_stat", S_STAT, 64'(ADR));
        expect_v("bad_store_not_halted_yet", S_HALT, 64'h0);
        issue(4'hA, 64'h40, 64'h99);
        expect_v("halted_after_adr", S_HALT, 64'h1);
        expect_v("pushq_stat", S_STAT, 64'(AOK));
        issue(4'h5, 64'h40, 64'h0);
        expect_v("pushq_blocked", S_VALM, 64'h0102030405060708);
        issue(4'h5, 64'(MEM_BYTES - 8), 64'h0);
        expect_v("bad_store_no_bytes", S_VALM, 64'hA5A5000011112222);
        issue(4'h5, 64'hFFFFFFFFFFFFFFFC, 64'h0);
        expect_v("wrap_load_valM", S_VALM, 64'h0);
        expect_v("wrap_load_stat", S_STAT, 64'(ADR));
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_v("rst_clears_halted", S_HALT, 64'h0);
        expect_v("rst_clears_stat", S_STAT, 64'(AOK));
        step();
        step();
        if (sb.size() != 0) begin
            tests += sb.size();
            fails += sb.size();
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
